clk_div_gen: RTL and testbench
==============================

# clk_div_gen

Programmable clock-enable and divided-clock generator that consumes the testbench/system clock and produces a divided reference clock (`clk_out`), a one-cycle rising-edge strobe (`tick`) and a `locked` indication for downstream stages. The divide ratio can be changed at run time through a req/ack handshake. Ratio changes take effect only on a period boundary, so `clk_out` never produces a runt pulse.

## Interface
- `CNT_W`, 8: width of ratio and phase counter; max ratio 2^CNT_W-1.
- `DEFAULT_DIV`, 2: ratio after reset; must satisfy 2 ≤ DEFAULT_DIV ≤ 2^CNT_W-1.
- `LOCK_CYCLES`, 4: number of complete `clk_out` periods after start or switch before `locked` rises.

- `clk`  in  1: the only clock.
- `rst`  in  1: reset, synchronous, active-high.
- `en`  in  1: run request, level.
- `div_req`  in  1: ratio-change request, level, held until `div_ack`.
- `div_val`  in  CNT_W: requested ratio, stable while `div_req`=1.
- `div_ack`  out  1: one-cycle pulse, request completed.
- `div_err`  out  1: one-cycle pulse with `div_ack`, request rejected.
- `clk_out`  out  1: divided clock, registered.
- `tick`  out  1: one-cycle pulse, coincident with `clk_out` 0→1.
- `locked`  out  1: ratio stable for LOCK_CYCLES periods.
- `div_cur`  out  CNT_W: ratio currently in effect.

## Operation
- N = `div_cur`. Phase counter `cnt` runs 0..N-1, then wraps.
- H = N - (N>>1), the ceiling of N/2, computed in CNT_W bits. `clk_out` = (next `cnt` < H). Odd N is high one cycle longer than low.
- `tick` = (next `cnt` == 0) while running.
- States:
  - STOP: `clk_out`=0, `cnt`=0.
    - `en`=1 → LOCK, starting a period on the same edge.
  - LOCK: counting wraps.
    - After LOCK_CYCLES wraps → RUN, with `locked`←1 on that wrap edge.
  - RUN: steady state.
  - PEND: valid request accepted and latched into `pend_val`; waits for the end of the current period.
- Request acceptance:
  - A request is sampled in STOP, LOCK or RUN.
  - `div_val` < 2 → `div_ack`=`div_err`=1 on the next edge. State and ratio are unchanged.
  - In STOP, a valid request loads `div_cur` and pulses `div_ack` on the next edge.
  - In LOCK or RUN, a valid request → PEND.
- Switch: in PEND, on the edge where `cnt`==N-1:
  - `div_cur`←`pend_val`, `cnt`←0, `div_ack`←1, `locked`←0.
  - If `en`=1: `clk_out`←1, `tick`←1, → LOCK.
  - If `en`=0: → STOP.
- Stop: `en`=0 in LOCK or RUN → the current period completes; on the edge where `cnt`==N-1 → STOP, `clk_out`←0, `locked`←0.
- `div_req` is ignored while in PEND and in the cycle immediately after `div_ack`.

## Timing
- Reset values: `clk_out`=0, `tick`=0, `locked`=0, `div_ack`=0, `div_err`=0, `div_cur`=DEFAULT_DIV, `cnt`=0, state STOP. `rst` overrides all other inputs.
- Start latency: `en` sampled 1 at edge k → `clk_out`=1 and `tick`=1 after edge k.
- Waveforms:
  - N=2: 1,0,1,0…
  - N=3: 1,1,0…
  - N=5: 1,1,1,0,0…
- `locked` rises on the edge ending the LOCK_CYCLES-th full period, i.e. LOCK_CYCLES·N cycles after start.
- Ack latency:
  - STOP or invalid request: 1 cycle.
  - Otherwise: edges remaining to period end, plus 1.
  - Maximum N+1.
- Simultaneous `en` fall and request in RUN: the request is accepted; the switch and stop happen on the same period end, and `div_ack` fires.
- `rst` mid-PEND: the request is discarded with no `div_ack`. The requester must re-issue after reset.

## Structure
- Package `clk_div_pkg` holds:
  - `clk_div_state_e` (STOP, LOCK, RUN, PEND).
  - `CLK_DIV_MIN` = 2.
  - The function computing H from N.
- One sub-module, `clk_div_phase`: phase counter plus `clk_out`/`tick` registers, with load/clear controls driven by the FSM.
- The bench monitors through an interface registered in `cdns_vif_registry`.

## Test plan
- Reset, then `en`=1 with DEFAULT_DIV=2, LOCK_CYCLES=4 → `clk_out` 1,0,…; `tick` every 2 cycles; `locked`=1 exactly 8 cycles after start.
- In RUN at N=2, `div_req` with `div_val`=5 mid-period → `clk_out` finishes its period; then 1,1,1,0,0 repeats; `div_ack` one pulse; `locked` drops and re-rises after 20 cycles; `div_cur`=5.
- `div_val`=1 and `div_val`=0 in RUN → `div_ack`+`div_err` on the next cycle; `div_cur` and `clk_out` undisturbed.
- `en`=0 at N=3 in mid-period → period completes, then `clk_out`=0 held and `locked`=0. A request in STOP with `div_val`=4 → acknowledged in 1 cycle; restarting gives 1,1,0,0.
- `rst` asserted in PEND (N=7→3) → all outputs reset; `div_cur`=DEFAULT_DIV; no `div_ack`.
- `div_val`=255 (CNT_W=8) → high 128 cycles, low 127 cycles; `tick` every 255 cycles.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    LOCK = 2'd1,
    RUN  = 2'd2,
    PEND = 2'd3
  } clk_div_state_e;

  localparam int unsigned CLK_DIV_MIN = 2;

  // Number of high cycles per period: ceil(n/2), so odd ratios lean high.
  function automatic int unsigned clk_div_high(input int unsigned n);
    return n - (n >> 1);
  endfunction

endpackage

// File: rtl/clk_div_phase.sv
// Phase counter with registered divided clock and rising-edge tick.
module clk_div_phase
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_run,
  input  logic             i_start,
  input  logic             i_clear,
  input  logic [CNT_W-1:0] i_div,
  output logic             o_clk_out,
  output logic             o_tick,
  output logic             o_last_c
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_clk_out;
  logic             r_tick;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_high;

  assign w_high    = CNT_W'(clk_div_high(32'(i_div)));
  assign o_last_c  = (r_cnt == (i_div - CNT_W'(1)));
  assign w_cnt_nxt = o_last_c ? '0 : (r_cnt + CNT_W'(1));

  // Outputs are derived from the phase the counter is about to enter.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt     <= '0;
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
    end else if (i_start) begin
      r_cnt     <= '0;
      r_clk_out <= 1'b1;
      r_tick    <= 1'b1;
    end else if (i_run) begin
      r_cnt     <= w_cnt_nxt;
      r_clk_out <= (w_cnt_nxt < w_high);
      r_tick    <= (w_cnt_nxt == '0);
    end
  end

  assign o_clk_out = r_clk_out;
  assign o_tick    = r_tick;

endmodule

// File: rtl/clk_div_gen.sv
// Clock-enable / divided-clock generator with glitch-free run-time ratio switching.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEFAULT_DIV = 2,
  parameter int unsigned LOCK_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_req,
  input  logic [CNT_W-1:0] div_val,
  output logic             div_ack,
  output logic             div_err,
  output logic             clk_out,
  output logic             tick,
  output logic             locked,
  output logic [CNT_W-1:0] div_cur
);

  localparam int unsigned WRAP_W = $clog2(LOCK_CYCLES + 1);

  clk_div_state_e   r_state;
  clk_div_state_e   w_state_nxt;
  logic [CNT_W-1:0] r_div_cur;
  logic [CNT_W-1:0] r_pend_val;
  logic             r_div_ack;
  logic             r_div_err;
  logic             r_locked;
  logic [WRAP_W-1:0] r_wraps;

  logic             w_last;
  logic             w_req_ok;
  logic             w_req_bad;
  logic             w_req_good;
  logic             w_lock_done;

  logic             w_run;
  logic             w_start;
  logic             w_clear;
  logic             w_ack_nxt;
  logic             w_err_nxt;
  logic [CNT_W-1:0] w_div_nxt;
  logic             w_latch_pend;
  logic             w_locked_nxt;
  logic [WRAP_W-1:0] w_wraps_nxt;

  // A request still visible in the cycle right after an ack is the old one.
  assign w_req_ok    = div_req && !r_div_ack;
  assign w_req_bad   = w_req_ok && (div_val < CNT_W'(CLK_DIV_MIN));
  assign w_req_good  = w_req_ok && !w_req_bad;
  assign w_lock_done = w_last && (r_wraps == WRAP_W'(LOCK_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= STOP;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      STOP: begin
        if (en) w_state_nxt = LOCK;
      end
      LOCK: begin
        if (w_req_good)           w_state_nxt = PEND;
        else if (w_last && !en)   w_state_nxt = STOP;
        else if (w_lock_done)     w_state_nxt = RUN;
      end
      RUN: begin
        if (w_req_good)           w_state_nxt = PEND;
        else if (w_last && !en)   w_state_nxt = STOP;
      end
      PEND: begin
        if (w_last) w_state_nxt = en ? LOCK : STOP;
      end
      default: w_state_nxt = STOP;
    endcase
  end

  // Phase controls and next values of the registered status outputs.
  always_comb begin
    w_run        = 1'b0;
    w_start      = 1'b0;
    w_clear      = 1'b0;
    w_ack_nxt    = 1'b0;
    w_err_nxt    = 1'b0;
    w_div_nxt    = r_div_cur;
    w_latch_pend = 1'b0;
    w_locked_nxt = r_locked;
    w_wraps_nxt  = r_wraps;
    case (r_state)
      STOP: begin
        if (w_req_ok) begin
          w_ack_nxt = 1'b1;
          w_err_nxt = w_req_bad;
          if (w_req_good) w_div_nxt = div_val;
        end
        if (en) begin
          w_start     = 1'b1;
          w_wraps_nxt = '0;
        end
      end
      LOCK, RUN: begin
        w_run        = 1'b1;
        w_ack_nxt    = w_req_bad;
        w_err_nxt    = w_req_bad;
        w_latch_pend = w_req_good;
        if (!w_req_good && w_last) begin
          if (!en) begin
            w_clear      = 1'b1;
            w_locked_nxt = 1'b0;
          end else if (r_state == LOCK) begin
            if (w_lock_done) w_locked_nxt = 1'b1;
            else             w_wraps_nxt  = r_wraps + WRAP_W'(1);
          end
        end
      end
      PEND: begin
        w_run = 1'b1;
        if (w_last) begin
          w_div_nxt    = r_pend_val;
          w_ack_nxt    = 1'b1;
          w_locked_nxt = 1'b0;
          w_wraps_nxt  = '0;
          w_clear      = !en;
        end
      end
      default: w_clear = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cur  <= CNT_W'(DEFAULT_DIV);
      r_pend_val <= '0;
      r_div_ack  <= 1'b0;
      r_div_err  <= 1'b0;
      r_locked   <= 1'b0;
      r_wraps    <= '0;
    end else begin
      r_div_cur  <= w_div_nxt;
      if (w_latch_pend) r_pend_val <= div_val;
      r_div_ack  <= w_ack_nxt;
      r_div_err  <= w_err_nxt;
      r_locked   <= w_locked_nxt;
      r_wraps    <= w_wraps_nxt;
    end
  end

  clk_div_phase #(
    .CNT_W (CNT_W)
  ) u_phase (
    .clk       (clk),
    .rst       (rst),
    .i_run     (w_run),
    .i_start   (w_start),
    .i_clear   (w_clear),
    .i_div     (r_div_cur),
    .o_clk_out (clk_out),
    .o_tick    (tick),
    .o_last_c  (w_last)
  );

  assign div_ack = r_div_ack;
  assign div_err = r_div_err;
  assign locked  = r_locked;
  assign div_cur = r_div_cur;

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: period-level reference model plus directed literal checks.
module tb_clk_div_gen;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned DEF   = 2;
  localparam int unsigned LCK   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             div_req = 1'b0;
  logic [CNT_W-1:0] div_val = '0;
  logic             div_ack, div_err, clk_out, tick, locked;
  logic [CNT_W-1:0] div_cur;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  clk_div_gen #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEF),
    .LOCK_CYCLES (LCK)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .div_req (div_req),
    .div_val (div_val),
    .div_ack (div_ack),
    .div_err (div_err),
    .clk_out (clk_out),
    .tick    (tick),
    .locked  (locked),
    .div_cur (div_cur)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase index within the current period, periods seen since start.
  bit m_run = 0, m_pend = 0, m_clk = 0, m_tick = 0, m_locked = 0, m_ack = 0, m_err = 0;
  int m_n = DEF, m_ph = 0, m_per = 0, m_pval = 0;

  always @(posedge clk) begin : model
    bit req_ok, was_pend, just_acc, last, na, ne;
    if (rst) begin
      m_run = 0; m_pend = 0; m_ph = 0; m_per = 0; m_n = DEF;
      m_locked = 0; m_ack = 0; m_err = 0; m_clk = 0; m_tick = 0;
    end else begin
      req_ok = div_req && !m_ack && !m_pend;
      na = 0; ne = 0;
      if (!m_run) begin
        if (req_ok) begin
          na = 1;
          if (div_val < 2) ne = 1;
          else m_n = int'(div_val);
        end
        if (en) begin m_run = 1; m_ph = 0; m_per = 0; end
      end else begin
        last = (m_ph == m_n - 1);
        was_pend = m_pend;
        just_acc = 0;
        if (req_ok) begin
          if (div_val < 2) begin na = 1; ne = 1; end
          else begin m_pend = 1; m_pval = int'(div_val); just_acc = 1; end
        end
        if (!last) m_ph++;
        else begin
          m_ph = 0;
          if (was_pend) begin
            m_n = m_pval; m_pend = 0; na = 1; m_per = 0; m_locked = 0;
            if (!en) m_run = 0;
          end else if (!just_acc) begin
            if (!en) begin m_run = 0; m_locked = 0; end
            else if (!m_locked) begin
              m_per++;
              if (m_per >= LCK) m_locked = 1;
            end
          end
        end
      end
      m_ack  = na;
      m_err  = ne;
      m_clk  = m_run && (m_ph < (m_n + 1) / 2);
      m_tick = m_run && (m_ph == 0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("clk_out", 32'(clk_out), 32'(m_clk));
      check("tick",    32'(tick),    32'(m_tick));
      check("locked",  32'(locked),  32'(m_locked));
      check("div_ack", 32'(div_ack), 32'(m_ack));
      check("div_err", 32'(div_err), 32'(m_err));
      check("div_cur", 32'(div_cur), 32'(m_n));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_req(input logic [CNT_W-1:0] v, output int lat);
    div_val = v;
    div_req = 1'b1;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!div_ack && lat < 600);
    check("req_ack_seen", 32'(div_ack), 1);
    div_req = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_clk_out"}, 32'(clk_out), 0);
    check({tag, "_tick"},    32'(tick),    0);
    check({tag, "_locked"},  32'(locked),  0);
    check({tag, "_ack"},     32'(div_ack), 0);
    check({tag, "_err"},     32'(div_err), 0);
    check({tag, "_div_cur"}, 32'(div_cur), DEF);
  endtask

  initial begin
    int lat, hi, lo, per;
    int pat5 [5];
    int pat4 [5];
    bit hold;
    pat5 = '{1, 1, 1, 0, 0};
    pat4 = '{1, 1, 0, 0, 1};

    repeat (3) step();
    chk_en = 1'b1;
    check_reset("rst");
    rst = 1'b0;

    // Start at N=2: 1,0,... with lock after 8 cycles.
    en = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      check("n2_clk", 32'(clk_out), 32'(i % 2));
      check("n2_tick", 32'(tick), 32'(i % 2));
      if (i == 8) check("n2_locked_early", 32'(locked), 0);
      if (i == 9) check("n2_locked", 32'(locked), 1);
    end

    // Switch to N=5 while running.
    step();
    do_req(8'd5, lat);
    check("n5_lat", 32'(lat <= 3), 1);
    check("n5_err", 32'(div_err), 0);
    check("n5_cur", 32'(div_cur), 5);
    for (int j = 0; j <= 20; j++) begin
      if (j > 0) step();
      check("n5_clk", 32'(clk_out), 32'(pat5[j % 5]));
      check("n5_tick", 32'(tick), 32'((j % 5) == 0));
      if (j == 1) check("n5_ack_pulse", 32'(div_ack), 0);
      if (j == 19) check("n5_locked_early", 32'(locked), 0);
      if (j == 20) check("n5_locked", 32'(locked), 1);
    end

    // Invalid ratios are rejected on the next cycle.
    for (int k = 1; k >= 0; k--) begin
      step();
      div_val = 8'(k);
      div_req = 1'b1;
      step();
      check("bad_ack", 32'(div_ack), 1);
      check("bad_err", 32'(div_err), 1);
      check("bad_cur", 32'(div_cur), 5);
      check("bad_locked", 32'(locked), 1);
      div_req = 1'b0;
      step();
      check("bad_ack_pulse", 32'(div_ack), 0);
    end

    // N=3, let it lock, then stop on a period start.
    do_req(8'd3, lat);
    check("n3_lat", 32'(lat <= 6), 1);
    repeat (13) step();
    per = 0;
    while (!tick && per < 10) begin step(); per++; end
    check("n3_tick_found", 32'(tick), 1);
    en = 1'b0;
    step();
    check("stop_clk1", 32'(clk_out), 1);
    check("stop_lock1", 32'(locked), 1);
    step();
    check("stop_clk2", 32'(clk_out), 0);
    for (int j = 3; j <= 5; j++) begin
      step();
      check("stop_clk", 32'(clk_out), 0);
      check("stop_locked", 32'(locked), 0);
      check("stop_tick", 32'(tick), 0);
    end

    // Ratio load while stopped, then restart at N=4.
    do_req(8'd4, lat);
    check("stop_req_lat", 32'(lat), 1);
    check("stop_req_cur", 32'(div_cur), 4);
    en = 1'b1;
    for (int j = 0; j < 5; j++) begin
      step();
      check("n4_clk", 32'(clk_out), 32'(pat4[j]));
    end

    // Reset while a 7->3 switch is pending discards it.
    do_req(8'd7, lat);
    check("n7_cur", 32'(div_cur), 7);
    step();
    step();
    div_val = 8'd3;
    div_req = 1'b1;
    step();
    check("pend_no_ack", 32'(div_ack), 0);
    rst = 1'b1;
    div_req = 1'b0;
    step();
    check_reset("pend_rst");
    rst = 1'b0;
    for (int j = 0; j < 10; j++) begin
      step();
      check("pend_rst_ack", 32'(div_ack), 0);
    end
    check("pend_rst_cur", 32'(div_cur), DEF);

    // Maximum ratio: 128 high, 127 low, tick every 255.
    en = 1'b0;
    repeat (4) step();
    do_req(8'd255, lat);
    check("n255_lat", 32'(lat), 1);
    en = 1'b1;
    step();
    hi = 0;
    while (clk_out == 1'b1 && hi < 300) begin hi++; step(); end
    check("n255_high", 32'(hi), 128);
    lo = 0;
    while (clk_out == 1'b0 && lo < 300) begin lo++; step(); end
    check("n255_low", 32'(lo), 127);
    check("n255_tick_rise", 32'(tick), 1);
    per = 0;
    do begin step(); per++; end while (!tick && per < 300);
    check("n255_tick_period", 32'(per), 255);

    // Randomized traffic against the model.
    hold = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      step();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        div_req = 1'b0;
        hold = 1'b0;
      end
      if ($urandom_range(0, 39) == 0) en = ~en;
      if (hold) begin
        div_req = 1'b0;
        hold = 1'b0;
      end else if (div_req && div_ack) begin
        if ($urandom_range(0, 1) == 1) hold = 1'b1;
        else div_req = 1'b0;
      end else if (!div_req && !rst && $urandom_range(0, 19) == 0) begin
        lo = int'($urandom_range(0, 9));
        if (lo >= 8) div_val = 8'($urandom_range(0, 12));
        else div_val = 8'(lo);
        div_req = 1'b1;
      end
    end

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
